// File: rtl/tdm_demux_1xn_if.sv
// Serial-link bundle between a TDM sender (master) and the 1xN demultiplexer (slave).
interface tdm_demux_1xn_if #(
  parameter int N  = 8,
  parameter int SW = $clog2(N + 1)
) ();
  logic          din;
  logic          din_valid;
  logic          frame_start;
  logic [SW-1:0] slot;
  logic [N-1:0]  dout;
  logic          frame_valid;
  logic          frame_abort;
  logic          parity_err;

  modport master (
    output din, din_valid, frame_start,
    input  slot, dout, frame_valid, frame_abort, parity_err
  );

  modport slave (
    input  din, din_valid, frame_start,
    output slot, dout, frame_valid, frame_abort, parity_err
  );
endinterface

// File: rtl/tdm_demux_1xn.sv
// Time-division demultiplexer: rebuilds an N-bit word from one serial bit per valid cycle.
// Optional macro TDM_DEMUX_PARITY_EN appends an even-parity slot N to every frame.
module tdm_demux_1xn #(
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                rst,
  tdm_demux_1xn_if.slave      bus
);
  localparam int SW = $clog2(N + 1);
`ifdef TDM_DEMUX_PARITY_EN
  localparam int LAST = N;
`else
  localparam int LAST = N - 1;
`endif

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [N-1:0]  shadow_q, shadow_d;
  logic [N-1:0]  dout_q, dout_d;
  logic          frame_valid_q, frame_valid_d;
  logic          frame_abort_q, frame_abort_d;
  logic          parity_err_q, parity_err_d;

  // Next-state and next-output decode for the slot sweep.
  always_comb begin
    state_d       = state_q;
    slot_d        = slot_q;
    shadow_d      = shadow_q;
    dout_d        = dout_q;
    frame_valid_d = 1'b0;
    frame_abort_d = 1'b0;
    parity_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.din_valid && bus.frame_start) begin
          shadow_d[0] = bus.din;
          slot_d      = SW'(1);
          state_d     = COLLECT;
        end else begin
          state_d = IDLE;
        end
      end
      COLLECT: begin
        if (!bus.din_valid) begin
          state_d = COLLECT;
        end else if (bus.frame_start) begin
          // Resync: the partial frame is dropped, stale shadow bits get overwritten.
          frame_abort_d = 1'b1;
          shadow_d[0]   = bus.din;
          slot_d        = SW'(1);
        end else if (slot_q == SW'(LAST)) begin
`ifdef TDM_DEMUX_PARITY_EN
          dout_d       = shadow_q;
          parity_err_d = ^{shadow_q, bus.din};
`else
          dout_d       = {bus.din, shadow_q[N-2:0]};
`endif
          frame_valid_d = 1'b1;
          slot_d        = SW'(0);
          state_d       = IDLE;
        end else begin
          for (int i = 0; i < N; i++) begin
            shadow_d[i] = (slot_q == SW'(i)) ? bus.din : shadow_q[i];
          end
          slot_d = slot_q + SW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = SW'(0);
      end
    endcase
  end

  // State and registered outputs; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      slot_q        <= SW'(0);
      shadow_q      <= {N{1'b0}};
      dout_q        <= {N{1'b0}};
      frame_valid_q <= 1'b0;
      frame_abort_q <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      dout_q        <= dout_d;
      frame_valid_q <= frame_valid_d;
      frame_abort_q <= frame_abort_d;
      parity_err_q  <= parity_err_d;
    end
  end

  assign bus.slot        = slot_q;
  assign bus.dout        = dout_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_abort = frame_abort_q;
  assign bus.parity_err  = parity_err_q;
endmodule

// File: tb/tb_tdm_demux_1xn.sv
// Table-driven bench for tdm_demux_1xn with a scoreboard of completed words.
module tb_tdm_demux_1xn;
  localparam int N = 8;
`ifdef TDM_DEMUX_PARITY_EN
  localparam int NF = N + 1;
`else
  localparam int NF = N;
`endif

  logic clk = 1'b0;
  logic rst;

  tdm_demux_1xn_if #(.N(N)) bus ();
  tdm_demux_1xn #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       fs;
    logic       dv;
    logic       d;
    logic [3:0] slot;
    logic [7:0] dout;
    logic       fv;
    logic       fa;
    logic       pe;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] sb[$];
  logic [7:0] mdout;
  int         total  = 0;
  int         passed = 0;

  task automatic add(input logic r, input logic fs, input logic dv, input logic d,
                     input logic [3:0] s, input logic fv, input logic fa, input logic pe);
    vec_t v;
    v.r = r; v.fs = fs; v.dv = dv; v.d = d;
    v.slot = s; v.dout = mdout; v.fv = fv; v.fa = fa; v.pe = pe;
    vecs.push_back(v);
  endtask

  // Full frame LSB-first; 3-cycle gaps (with a stray frame_start) after bits gap_a/gap_b.
  task automatic add_frame(input logic [7:0] w, input int gap_a, input int gap_b,
                           input logic resync, input logic pflip);
    for (int i = 0; i < NF; i++) begin
      logic b;
      logic last;
      if (i < N) b = w[i];
      else       b = (^w) ^ pflip;
      last = (i == NF - 1);
      if (last) mdout = w;
      add(1'b0, i == 0, 1'b1, b, last ? 4'd0 : 4'(i + 1), last,
          resync && (i == 0), last && pflip && (NF > N));
      if (i == gap_a || i == gap_b) begin
        for (int g = 0; g < 3; g++)
          add(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 4'(i + 1), 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic add_partial(input logic [7:0] w, input int k);
    for (int i = 0; i < k; i++)
      add(1'b0, i == 0, 1'b1, w[i], 4'(i + 1), 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
  endtask

  initial begin
    rst             = 1'b1;
    bus.din         = 1'b0;
    bus.din_valid   = 1'b0;
    bus.frame_start = 1'b0;
    mdout           = 8'h00;

    add(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    add_frame(8'b11001011, -1, -1, 1'b0, 1'b0);
    add_frame(8'b11001011, 2, 5, 1'b0, 1'b0);
    add_partial(8'hFF, 4);
    add_frame(8'b00110101, -1, -1, 1'b1, 1'b0);
    add_frame(8'hA5, -1, -1, 1'b0, 1'b0);
    add_frame(8'h3C, -1, -1, 1'b0, 1'b0);
    add_partial(8'h5A, 5);
    mdout = 8'h00;
    add(1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    add_frame(8'b11001011, -1, -1, 1'b0, 1'b1);
    add_frame(8'b11001011, -1, -1, 1'b0, 1'b0);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst             = vecs[k].r;
      bus.frame_start = vecs[k].fs;
      bus.din_valid   = vecs[k].dv;
      bus.din         = vecs[k].d;
      if (vecs[k].fv) sb.push_back(vecs[k].dout);
      @(posedge clk);
      #1;
      check("slot", k, 32'(bus.slot), 32'(vecs[k].slot));
      check("frame_valid", k, 32'(bus.frame_valid), 32'(vecs[k].fv));
      check("frame_abort", k, 32'(bus.frame_abort), 32'(vecs[k].fa));
      check("parity_err", k, 32'(bus.parity_err), 32'(vecs[k].pe));
      check("dout", k, 32'(bus.dout), 32'(vecs[k].dout));
      check("fv_fa_excl", k, 32'(bus.frame_valid & bus.frame_abort), 32'd0);
      if (bus.frame_valid === 1'b1) begin
        if (sb.size() == 0) begin
          total++;
          $display("FAIL sb_unexpected vec %0d: got frame_valid=1 expected no pending word", k);
        end else begin
          logic [7:0] e;
          e = sb.pop_front();
          check("sb_dout", k, 32'(bus.dout), 32'(e));
        end
      end
    end
    check("sb_empty", 0, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
